// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, fetch reset/NOP defaults, and the
// {instr, pc} entry carried from instruction memory to decode.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FIFO,
        SRC_BYPASS
    } ifid_src_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] instr_addr;
    logic            instr_req;
    logic            instr_gnt;
    logic            instr_rvalid;
    logic [XLEN-1:0] instr;

    modport master (
        output instr_addr,
        output instr_req,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr
    );

    modport slave (
        input  instr_addr,
        input  instr_req,
        output instr_gnt,
        output instr_rvalid,
        output instr
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush; DEPTH must
// be a power of two so the pointers wrap naturally.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));

    // Storage carries no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_push |-> !o_full)
        else $error("fetch_fifo push while full");
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) w_pop |-> !o_empty)
        else $error("fetch_fifo pop while empty");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order requests, response FIFO,
// stale-response dropping after redirects, and the IF/ID pipeline register.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        bus,
    input  logic                stall,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic [XLEN-1:0]     IF_ID_instr,
    output logic [XLEN-1:0]     IF_ID_pc,
    output logic                IF_ID_valid
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_out_cnt;
    logic [CW-1:0]   r_drop_cnt;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_instr;
    logic [XLEN-1:0] r_ifid_pc;

    logic [CW:0]     w_credit_used;
    logic            w_req;
    logic            w_grant;
    logic            w_accept;
    logic            w_ifid_load;
    ifid_src_e       w_src;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_rsp_entry;
    fetch_entry_t    w_fifo_head;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic            w_fifo_full;

    // Outstanding requests plus buffered words share one credit pool, so every
    // in-flight response is guaranteed a FIFO slot.
    assign w_credit_used = {1'b0, r_out_cnt} + {1'b0, w_fifo_count};
    assign w_req         = !rst && !redirect && (w_credit_used < (CW+1)'(DEPTH));
    assign w_grant       = w_req && bus.instr_gnt;

    assign bus.instr_req  = w_req;
    assign bus.instr_addr = r_pc;

    assign w_accept    = bus.instr_rvalid && !redirect && (r_drop_cnt == '0);
    assign w_ifid_load = !r_ifid_valid || !stall;
    assign w_rsp_entry = '{instr: bus.instr, pc: r_resp_pc};

    always_comb begin
        w_src = SRC_NONE;
        if (!w_fifo_empty) begin
            w_src = SRC_FIFO;
        end else if (w_accept) begin
            w_src = SRC_BYPASS;
        end
    end

    assign w_pop  = !redirect && w_ifid_load && (w_src == SRC_FIFO);
    assign w_push = w_accept && !(w_ifid_load && (w_src == SRC_BYPASS));

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_rsp_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // A redirect turns every still-outstanding request into a drop; the
    // response arriving in the redirect cycle itself is already retired here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else if (redirect) begin
            r_pc       <= word_align(redirect_pc);
            r_resp_pc  <= word_align(redirect_pc);
            r_out_cnt  <= r_out_cnt - CW'(bus.instr_rvalid);
            r_drop_cnt <= r_out_cnt - CW'(bus.instr_rvalid);
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + XLEN'(4);
            end
            r_out_cnt <= r_out_cnt + CW'(w_grant) - CW'(bus.instr_rvalid);
            if (bus.instr_rvalid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_accept) begin
                r_resp_pc <= r_resp_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= RESET_PC;
        end else if (redirect) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
        end else if (w_ifid_load) begin
            unique case (w_src)
                SRC_FIFO: begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_instr <= w_fifo_head.instr;
                    r_ifid_pc    <= w_fifo_head.pc;
                end
                SRC_BYPASS: begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_instr <= w_rsp_entry.instr;
                    r_ifid_pc    <= w_rsp_entry.pc;
                end
                default: begin
                    r_ifid_valid <= 1'b0;
                    r_ifid_instr <= NOP_INSTR;
                end
            endcase
        end
    end

    assign IF_ID_valid = r_ifid_valid;
    assign IF_ID_instr = r_ifid_instr;
    assign IF_ID_pc    = r_ifid_pc;

    a_credit: assert property (@(posedge clk) disable iff (rst)
        (w_credit_used <= (CW+1)'(DEPTH)) && !(w_push && w_fifo_full && !w_pop))
        else $error("fetch_unit credit invariant violated");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a queue-based instruction
// memory whose response latency is gated per cycle.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_valid (IF_ID_valid)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        bit          rst;
        bit          stl;
        bit          gnt;
        bit          ren;
        bit          rdr;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        vq [$];
    logic [31:0] mq [$];
    int          n_checks = 0;
    int          n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t V(input bit r, input bit s, input bit g, input bit re,
                               input bit rd, input logic [31:0] rp, input bit q,
                               input logic [31:0] a, input bit v, input logic [31:0] p);
        vec_t t;
        t.rst = r; t.stl = s; t.gnt = g; t.ren = re; t.rdr = rd; t.rpc = rp;
        t.e_req = q; t.e_addr = a; t.e_val = v; t.e_pc = p;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive memory response for this cycle from the pending queue.
    task automatic mem_drive(input bit en);
        bus.instr_rvalid = en && (mq.size() > 0);
        bus.instr        = bus.instr_rvalid ? mem_word(mq[0]) : 32'h0;
    endtask

    // Called just before the active edge; retires/issues memory transactions.
    task automatic mem_edge(input bit in_rst);
        bit          took;
        logic [31:0] a;
        took = bus.instr_req && bus.instr_gnt;
        a    = bus.instr_addr;
        @(posedge clk);
        if (!in_rst) begin
            if (bus.instr_rvalid) void'(mq.pop_front());
            if (took) mq.push_back(a);
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        rst             = v.rst;
        stall           = v.stl;
        bus.instr_gnt   = v.gnt;
        redirect        = v.rdr;
        redirect_pc     = v.rpc;
        if (v.rst) mq.delete();
        mem_drive(!v.rst && v.ren);
        #1;
        chk($sformatf("row%0d_req", idx), {31'b0, bus.instr_req}, {31'b0, v.e_req});
        chk($sformatf("row%0d_addr", idx), bus.instr_addr, v.e_addr);
        chk($sformatf("row%0d_valid", idx), {31'b0, IF_ID_valid}, {31'b0, v.e_val});
        chk($sformatf("row%0d_instr", idx), IF_ID_instr, v.e_val ? mem_word(v.e_pc) : NOP);
        if (v.e_val || v.rst)
            chk($sformatf("row%0d_pc", idx), IF_ID_pc, v.e_pc);
        mem_edge(v.rst);
    endtask

    initial begin
        int lat;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b0; bus.instr = '0;

        //          rst stl gnt ren rdr rpc            req addr           val pc
        vq.push_back(V(1, 0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0));
        vq.push_back(V(1, 0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'hC,          1, 32'h4));
        vq.push_back(V(0, 1, 1, 1, 0, 32'h0,          1, 32'h10,         1, 32'h8));
        vq.push_back(V(0, 1, 1, 1, 0, 32'h0,          0, 32'h14,         1, 32'h8));
        vq.push_back(V(0, 1, 1, 1, 0, 32'h0,          0, 32'h14,         1, 32'h8));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          0, 32'h14,         1, 32'h8));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h14,         1, 32'hC));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h18,         1, 32'h10));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h1C,         1, 32'h14));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h20,         1, 32'h18));
        vq.push_back(V(0, 0, 0, 1, 0, 32'h0,          1, 32'h24,         1, 32'h1C));
        vq.push_back(V(0, 0, 0, 1, 0, 32'h0,          1, 32'h24,         1, 32'h20));
        vq.push_back(V(0, 0, 0, 1, 0, 32'h0,          1, 32'h24,         0, 32'h0));
        vq.push_back(V(0, 0, 0, 1, 0, 32'h0,          1, 32'h24,         0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h24,         0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h28,         0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h2C,         1, 32'h24));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h30,         1, 32'h28));
        vq.push_back(V(0, 0, 1, 0, 0, 32'h0,          1, 32'h34,         1, 32'h2C));
        vq.push_back(V(0, 0, 1, 1, 1, 32'h103,        0, 32'h38,         0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h100,        0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h104,        0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h108,        1, 32'h100));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h10C,        1, 32'h104));
        vq.push_back(V(0, 1, 1, 1, 1, 32'h200,        0, 32'h110,        1, 32'h108));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h200,        0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h204,        0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h208,        1, 32'h200));
        vq.push_back(V(0, 0, 1, 1, 1, 32'hFFFF_FFFA,  0, 32'h20C,        1, 32'h204));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFF8,  0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFF8));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFFC));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0));
        vq.push_back(V(1, 0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0));
        vq.push_back(V(0, 0, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0));

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            run_vec(i, vq[i]);
        end

        // Reset pulsed in the middle of a cycle, away from any clock edge.
        mem_drive(1'b1);
        #3;
        rst = 1'b1;
        bus.instr_rvalid = 1'b0;
        mq.delete();
        #1;
        chk("async_rst_req", {31'b0, bus.instr_req}, 32'h0);
        chk("async_rst_addr", bus.instr_addr, 32'h0);
        chk("async_rst_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("async_rst_instr", IF_ID_instr, NOP);
        chk("async_rst_pc", IF_ID_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Restart from RESET_PC: first IF/ID word must land two cycles later.
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            mem_drive(1'b1);
            #1;
            if (IF_ID_valid) lat = k;
            else mem_edge(1'b0);
        end
        chk("restart_latency", lat, 2);
        chk("restart_pc", IF_ID_pc, 32'h0);
        chk("restart_instr", IF_ID_instr, mem_word(32'h0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
